// File: rtl/pe_ctx_sequencer_if.sv
// rtl/pe_ctx_sequencer_if.sv - config, run-control and PE-drive signals of the context sequencer.
// Readback signals exist only when PE_CTX_READBACK_EN is defined.
interface pe_ctx_sequencer_if #(
  parameter int NUM_PE  = 4,
  parameter int NUM_CTX = 4,
  parameter int CTRL_W  = 8
);
  localparam int CW = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic                     cfg_start;
  logic [3:0]               cfg_nibble;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic                     cfg_done;
  logic                     run_start;
  logic [7:0]               run_passes;
  logic                     stop;
  logic [NUM_PE*CTRL_W-1:0] pe_ctrl;
  logic                     pe_en;
  logic [CW-1:0]            ctx_idx;
  logic                     busy;
  logic                     run_done;
`ifdef PE_CTX_READBACK_EN
  logic [CW-1:0]            rd_ctx;
  logic [PW-1:0]            rd_pe;
  logic [CTRL_W-1:0]        rd_data;
`endif

  modport master (
    output cfg_start, cfg_nibble, cfg_valid, run_start, run_passes, stop,
`ifdef PE_CTX_READBACK_EN
    output rd_ctx, rd_pe,
    input  rd_data,
`endif
    input  cfg_ready, cfg_done, pe_ctrl, pe_en, ctx_idx, busy, run_done
  );

  modport slave (
    input  cfg_start, cfg_nibble, cfg_valid, run_start, run_passes, stop,
`ifdef PE_CTX_READBACK_EN
    input  rd_ctx, rd_pe,
    output rd_data,
`endif
    output cfg_ready, cfg_done, pe_ctrl, pe_en, ctx_idx, busy, run_done
  );
endinterface

// File: rtl/pe_ctx_sequencer.sv
// rtl/pe_ctx_sequencer.sv - loads a PE context table over a nibble port and replays it onto the PE row.
// Optional table readback port enabled by PE_CTX_READBACK_EN.
module pe_ctx_sequencer #(
  parameter int NUM_PE  = 4,
  parameter int NUM_CTX = 4,
  parameter int CTRL_W  = 8
) (
  input logic               clock,
  input logic               reset_n,
  pe_ctx_sequencer_if.slave bus
);
  localparam int N_WORDS = NUM_CTX * NUM_PE;
  localparam int IDX_W   = $clog2(N_WORDS);
  localparam int CW      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam int NIBS    = CTRL_W / 4;
  localparam int NB_W    = (NIBS > 1) ? $clog2(NIBS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                   state;
  logic [CTRL_W-1:0]        table_q [N_WORDS];
  logic [CTRL_W-1:0]        asm_q;
  logic [NB_W-1:0]          nib_cnt;
  logic [IDX_W-1:0]         wr_idx;
  logic [7:0]               passes_q;
  logic [7:0]               pass_cnt;
  logic [CW-1:0]            ctx_q;
  logic [NUM_PE*CTRL_W-1:0] ctrl_q;
  logic                     pe_en_q;
  logic                     busy_q;
  logic                     cfg_ready_q;
  logic                     cfg_done_q;
  logic                     run_done_q;

  // New nibble enters at the top so the first nibble ends up in bits [3:0].
  logic [CTRL_W+3:0]        shift_w;
  logic [CTRL_W-1:0]        word_w;
  logic                     xfer;
  logic                     last_nib;
  logic                     last_word;
  logic                     last_ctx;
  logic                     final_pass;
  logic [CW-1:0]            ctx_next;

  assign shift_w    = {bus.cfg_nibble, asm_q};
  assign word_w     = shift_w[CTRL_W+3:4];
  assign xfer       = bus.cfg_valid && cfg_ready_q;
  assign last_nib   = (nib_cnt == NB_W'(NIBS - 1));
  assign last_word  = (wr_idx == IDX_W'(N_WORDS - 1));
  assign last_ctx   = (ctx_q == CW'(NUM_CTX - 1));
  assign final_pass = (passes_q != 8'd0) && (pass_cnt == passes_q - 8'd1);
  assign ctx_next   = ctx_q + CW'(1);

  function automatic logic [NUM_PE*CTRL_W-1:0] row_of(input logic [CW-1:0] c);
    logic [NUM_PE*CTRL_W-1:0] r;
    r = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      r[p*CTRL_W +: CTRL_W] = table_q[IDX_W'(int'(c) * NUM_PE + p)];
    end
    return r;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      asm_q       <= '0;
      nib_cnt     <= '0;
      wr_idx      <= '0;
      passes_q    <= '0;
      pass_cnt    <= '0;
      ctx_q       <= '0;
      ctrl_q      <= '0;
      pe_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      run_done_q  <= 1'b0;
      for (int i = 0; i < N_WORDS; i++) table_q[i] <= '0;
    end else begin
      cfg_done_q <= 1'b0;
      run_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_start) begin
            state       <= LOAD;
            busy_q      <= 1'b1;
            cfg_ready_q <= 1'b1;
            nib_cnt     <= '0;
            wr_idx      <= '0;
            asm_q       <= '0;
          end else if (bus.run_start) begin
            state    <= RUN;
            busy_q   <= 1'b1;
            passes_q <= bus.run_passes;
            pass_cnt <= '0;
            ctx_q    <= '0;
            ctrl_q   <= row_of('0);
            pe_en_q  <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.stop) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
          end else if (xfer) begin
            asm_q <= word_w;
            if (last_nib) begin
              nib_cnt         <= '0;
              table_q[wr_idx] <= word_w;
              if (last_word) begin
                state       <= IDLE;
                busy_q      <= 1'b0;
                cfg_ready_q <= 1'b0;
                cfg_done_q  <= 1'b1;
              end else begin
                wr_idx <= wr_idx + IDX_W'(1);
              end
            end else begin
              nib_cnt <= nib_cnt + NB_W'(1);
            end
          end
        end
        RUN: begin
          // pe_ctrl and ctx_idx are left holding the last context on exit.
          if (bus.stop || (last_ctx && final_pass)) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            pe_en_q    <= 1'b0;
            run_done_q <= 1'b1;
          end else begin
            ctx_q  <= ctx_next;
            ctrl_q <= row_of(ctx_next);
            if (last_ctx) pass_cnt <= pass_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pe_ctrl   = ctrl_q;
  assign bus.pe_en     = pe_en_q;
  assign bus.ctx_idx   = ctx_q;
  assign bus.busy      = busy_q;
  assign bus.cfg_ready = cfg_ready_q;
  assign bus.cfg_done  = cfg_done_q;
  assign bus.run_done  = run_done_q;

`ifdef PE_CTX_READBACK_EN
  logic [CTRL_W-1:0] rd_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else if (int'(bus.rd_pe) < NUM_PE) begin
      rd_q <= table_q[IDX_W'(int'(bus.rd_ctx) * NUM_PE + int'(bus.rd_pe))];
    end else begin
      rd_q <= '0;
    end
  end
  assign bus.rd_data = rd_q;
`endif
endmodule
